// File: rtl/mem_responder.sv
// Single-ported 16-bit word memory responder with fixed request-to-response latency.
// One request in flight; a new request may be accepted in the response cycle of the previous one.
`timescale 1ns/1ps
module mem_responder #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        busy
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                accept_c;
  logic                access_c;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  // Byte-address bit 0 and bits above the word index play no part in addressing.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[15:ADDR_W+1], addr[0]};

  assign accept_c = enable && (state_q != S_WAIT);
  assign access_c = (state_q == S_WAIT) && (cnt_q == '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept_c) state_d = S_WAIT;
      S_WAIT: if (cnt_q == '0) state_d = S_RESP;
      S_RESP: state_d = accept_c ? S_WAIT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    busy_d  = (state_d == S_WAIT);
    valid_d = (state_d == S_RESP);
    if (accept_c) begin
      cnt_d   = CNT_W'(LATENCY - 1);
      wr_d    = wr;
      idx_d   = addr[ADDR_W:1];
      wdata_d = data_in;
    end else if ((state_q == S_WAIT) && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    if (access_c && !wr_q) begin
      dout_d = mem_q[idx_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  // Storage is deliberately not reset; reset only aborts the pending access.
  always_ff @(posedge clk) begin
    if (access_c && wr_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign data_out   = dout_q;
  assign data_valid = valid_q;
  assign busy       = busy_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, giving the word-index width (depth = 2^ADDR_W 16-bit words).
REQ-002 SHALL have parameter LATENCY, default 4, giving cycles from request acceptance to response (legal range 1..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port enable, input, 1, initiator request strobe.
REQ-006 SHALL have port wr, input, 1, 1=write, 0=read; qualified by enable.
REQ-007 SHALL have port addr, input, 16, byte address.
REQ-008 SHALL have port data_in, input, 16, write data.
REQ-009 SHALL have port data_out, output, 16, read data, registered.
REQ-010 SHALL have port data_valid, output, 1, one-cycle completion pulse for reads and writes.
REQ-011 SHALL have port busy, output, 1, high while a request is in flight and no new request can be accepted.

Function
REQ-012 SHALL accept a request at a rising edge where enable=1 and busy=0, capturing wr, addr, and data_in into internal registers at that edge.
REQ-013 SHALL ignore enable, wr, addr, and data_in while busy=1; the initiator holds the request until data_valid.
REQ-014 SHALL use a three-state FSM: IDLE, WAIT, RESP.
REQ-015 SHALL transition IDLE->WAIT on accept; WAIT->RESP at the edge where the countdown is 0; RESP->WAIT on accept; RESP->IDLE otherwise.
REQ-016 SHALL load the countdown with LATENCY-1 on accept and decrement it once per cycle in WAIT.
REQ-017 SHALL drive busy=1 exactly while state=WAIT; busy=0 in IDLE and RESP, so back-to-back requests are accepted during RESP.
REQ-018 SHALL drive data_valid=1 exactly while state=RESP, i.e. in the cycle LATENCY cycles after the accept edge.
REQ-019 SHALL form the word index from captured addr[ADDR_W:1]; addr[0] and bits above ADDR_W are ignored, so addresses wrap modulo 2^(ADDR_W+1) bytes.
REQ-020 SHALL perform the array access at the WAIT->RESP edge: a write stores the captured data_in; a read loads data_out with the array word.
REQ-021 SHALL leave data_out unchanged on write completion; data_out holds the last read value until the next read completes.
REQ-022 SHALL make a read issued after a write to the same word return the written data, since accesses complete in acceptance order.
REQ-023 SHALL NOT initialize array contents; reads of never-written words return X in simulation.

Reset
REQ-024 SHALL, while rst=1 (asynchronous, independent of clk), force state=IDLE, countdown=0, data_out=16'h0000, data_valid=0, and busy=0.
REQ-025 SHALL discard an in-flight request when rst asserts mid-operation; a pending write SHALL NOT reach the array, and no data_valid SHALL follow.
REQ-026 SHALL leave array contents unchanged by reset.
REQ-027 SHALL allow a request presented on the first rising edge after rst deasserts to be accepted.

Verification (LATENCY=4, ADDR_W=8)
REQ-028 Write: enable=1, wr=1, addr=0x0010, data_in=0xBEEF at edge T -> busy=1 for 4 cycles (T+1..T+4 edges), data_valid=1 one cycle after edge T+4, data_out still 0x0000.
REQ-029 Read-back: read addr=0x0010 after REQ-028 -> data_valid pulse 4 cycles after accept with data_out=0xBEEF, held after the pulse.
REQ-030 Back-to-back: enable held through writes 0x1111@0x0002, then 0x2222@0x0004, then read @0x0002 -> second request accepted in the RESP cycle of the first, 3 data_valid pulses spaced 5 cycles apart, final data_out=0x1111.
REQ-031 Alias/wrap: write 0xA5A5@0x0003, then read @0x0202 -> data_out=0xA5A5 (same word index 1).
REQ-032 Ignore while busy: during WAIT of a read, toggle addr and data_in and pulse wr -> the response reflects only the captured request, and no extra accept occurs.
REQ-033 Reset mid-write: accept write 0x5555@0x0020, assert rst 2 cycles later -> busy=0 and data_valid=0 immediately without waiting for a clock edge; a later read @0x0020 returns the prior contents, not 0x5555.
